ahbl_sram_fill_master: RTL

- AHB-Lite master that sits directly upstream of the AHB-Lite SRAM slave and drives its HSEL/HADDR/HTRANS/HWRITE/HWDATA inputs.
- On a start pulse it fills a word-aligned region of fabric SRAM with a constant or address-derived pattern, using back-to-back pipelined INCR word writes.
- Used for boot-time zeroing and ECC-seeding of SRAM before the processor is released onto the bus. A downstream bus mux hands the slave over when busy is low.

---
 rtl/ahbl_sram_fill_master_if.sv | 33 +++
 rtl/ahbl_sram_fill_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sram_fill_master_if.sv
// AHB-Lite bus bundle between the SRAM fill master and the SRAM slave/mux.
// HRDATA is present only when AHBL_SRAM_FILL_VERIFY_EN is defined.
interface ahbl_sram_fill_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HRESP;
`ifdef AHBL_SRAM_FILL_VERIFY_EN
  logic [31:0]       HRDATA;
`endif

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
`ifdef AHBL_SRAM_FILL_VERIFY_EN
    input  HRDATA,
`endif
    input  HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
`ifdef AHBL_SRAM_FILL_VERIFY_EN
    output HRDATA,
`endif
    output HREADY, HRESP
  );
endinterface

// File: rtl/ahbl_sram_fill_master.sv
// AHB-Lite SRAM fill master: writes a constant or address-derived pattern
// over a word-aligned region using pipelined INCR word writes, restarting
// with NONSEQ at every 2^KB_BOUNDARY byte boundary.
// Optional read-back verify pass: define AHBL_SRAM_FILL_VERIFY_EN.
module ahbl_sram_fill_master #(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int KB_BOUNDARY = 10
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              mode,
  input  logic [31:0]       pattern,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
`ifdef AHBL_SRAM_FILL_VERIFY_EN
  output logic [LEN_W-1:0]  mismatch_cnt,
`endif
  ahbl_sram_fill_master_if.master bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LAST  = 3'd2,
    S_ABORT = 3'd3,
    S_FIN   = 3'd4,
    S_RADDR = 3'd5,
    S_RLAST = 3'd6
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] haddr_r, haddr_nxt_s;
  logic [1:0]        htrans_r, htrans_nxt_s;
  logic              hwrite_r, hwrite_nxt_s;
  logic [31:0]       hwdata_r, hwdata_nxt_s;
  logic              busy_r, done_r;
  logic              err_r, err_nxt_s;
  logic [ADDR_W-1:0] err_addr_r, err_addr_nxt_s;
  logic [LEN_W-1:0]  rem_r, rem_nxt_s;
  logic              mode_r, mode_nxt_s;
  logic [31:0]       pattern_r, pattern_nxt_s;
  logic              dphase_r, dphase_nxt_s;
  logic [ADDR_W-1:0] daddr_r, daddr_nxt_s;
`ifdef AHBL_SRAM_FILL_VERIFY_EN
  logic [ADDR_W-1:0] base_r, base_nxt_s;
  logic [LEN_W-1:0]  len_r, len_nxt_s;
  logic [LEN_W-1:0]  mcnt_r, mcnt_nxt_s;
  logic              rd_bad_s;
`endif

  logic              err_cyc_s;
  logic              last_beat_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [ADDR_W-1:0] aligned_base_s;
  logic [1:0]        next_tr_s;

  // Value written to (or expected back from) the beat at byte address a.
  function automatic logic [31:0] fill_value(input logic m, input logic [ADDR_W-1:0] a,
                                             input logic [31:0] p);
    return m ? 32'(a) : p;
  endfunction

  // First ERROR cycle: a data phase is pending, slave stalls with HRESP=1.
  assign err_cyc_s      = dphase_r & ~bus.HREADY & bus.HRESP;
  assign next_addr_s    = haddr_r + ADDR_W'(32'd4);
  assign next_tr_s      = (next_addr_s[KB_BOUNDARY-1:0] == {KB_BOUNDARY{1'b0}}) ? TR_NONSEQ : TR_SEQ;
  assign last_beat_s    = (rem_r == {{(LEN_W-1){1'b0}}, 1'b1});
  assign aligned_base_s = base_addr & ~ADDR_W'(32'd3);
`ifdef AHBL_SRAM_FILL_VERIFY_EN
  assign rd_bad_s = dphase_r & bus.HREADY &
                    (bus.HRDATA != fill_value(mode_r, daddr_r, pattern_r));
`endif

  // FSM state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic; an ERROR cycle preempts every bus state.
  always_comb begin
    state_nxt_s = state_r;
    if (err_cyc_s) begin
      state_nxt_s = S_ABORT;
    end else begin
      case (state_r)
        S_IDLE:  state_nxt_s = start ? ((num_words != {LEN_W{1'b0}}) ? S_ADDR : S_FIN) : S_IDLE;
        S_ADDR:  state_nxt_s = (bus.HREADY && last_beat_s) ? S_LAST : S_ADDR;
`ifdef AHBL_SRAM_FILL_VERIFY_EN
        S_LAST:  state_nxt_s = bus.HREADY ? S_RADDR : S_LAST;
`else
        S_LAST:  state_nxt_s = bus.HREADY ? S_FIN : S_LAST;
`endif
        S_ABORT: state_nxt_s = bus.HREADY ? S_FIN : S_ABORT;
        S_FIN:   state_nxt_s = S_IDLE;
        S_RADDR: state_nxt_s = (bus.HREADY && last_beat_s) ? S_RLAST : S_RADDR;
        S_RLAST: state_nxt_s = bus.HREADY ? S_FIN : S_RLAST;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Bus and datapath next values; every register holds unless updated here.
  always_comb begin
    haddr_nxt_s    = haddr_r;
    htrans_nxt_s   = htrans_r;
    hwrite_nxt_s   = hwrite_r;
    hwdata_nxt_s   = hwdata_r;
    err_nxt_s      = err_r;
    err_addr_nxt_s = err_addr_r;
    rem_nxt_s      = rem_r;
    mode_nxt_s     = mode_r;
    pattern_nxt_s  = pattern_r;
    dphase_nxt_s   = dphase_r;
    daddr_nxt_s    = daddr_r;
`ifdef AHBL_SRAM_FILL_VERIFY_EN
    base_nxt_s     = base_r;
    len_nxt_s      = len_r;
    mcnt_nxt_s     = mcnt_r;
`endif
    if (err_cyc_s) begin
      // Cancel the pending address and record the failing beat.
      htrans_nxt_s   = TR_IDLE;
      hwrite_nxt_s   = 1'b0;
      err_nxt_s      = 1'b1;
      err_addr_nxt_s = daddr_r;
      dphase_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && (num_words != {LEN_W{1'b0}})) begin
            haddr_nxt_s    = aligned_base_s;
            htrans_nxt_s   = TR_NONSEQ;
            hwrite_nxt_s   = 1'b1;
            rem_nxt_s      = num_words;
            mode_nxt_s     = mode;
            pattern_nxt_s  = pattern;
            err_nxt_s      = 1'b0;
            err_addr_nxt_s = {ADDR_W{1'b0}};
            dphase_nxt_s   = 1'b0;
`ifdef AHBL_SRAM_FILL_VERIFY_EN
            base_nxt_s     = aligned_base_s;
            len_nxt_s      = num_words;
            mcnt_nxt_s     = {LEN_W{1'b0}};
`endif
          end else begin
            dphase_nxt_s = 1'b0;
          end
        end
        S_ADDR, S_RADDR: begin
          if (bus.HREADY) begin
            haddr_nxt_s  = next_addr_s;
            daddr_nxt_s  = haddr_r;
            dphase_nxt_s = 1'b1;
            rem_nxt_s    = rem_r - {{(LEN_W-1){1'b0}}, 1'b1};
            if (state_r == S_ADDR) hwdata_nxt_s = fill_value(mode_r, haddr_r, pattern_r);
            else                   hwdata_nxt_s = hwdata_r;
            if (last_beat_s) begin
              htrans_nxt_s = TR_IDLE;
              hwrite_nxt_s = 1'b0;
            end else begin
              htrans_nxt_s = next_tr_s;
            end
          end else begin
            haddr_nxt_s = haddr_r;
          end
        end
        S_LAST: begin
          if (bus.HREADY) begin
            dphase_nxt_s = 1'b0;
`ifdef AHBL_SRAM_FILL_VERIFY_EN
            // Write pass complete: restart at the base for the read-back.
            haddr_nxt_s  = base_r;
            htrans_nxt_s = TR_NONSEQ;
            hwrite_nxt_s = 1'b0;
            rem_nxt_s    = len_r;
`else
            htrans_nxt_s = TR_IDLE;
`endif
          end else begin
            htrans_nxt_s = TR_IDLE;
          end
        end
        S_RLAST: begin
          if (bus.HREADY) dphase_nxt_s = 1'b0;
          else            dphase_nxt_s = dphase_r;
        end
        S_ABORT, S_FIN: begin
          dphase_nxt_s = 1'b0;
        end
        default: begin
          htrans_nxt_s = TR_IDLE;
          dphase_nxt_s = 1'b0;
        end
      endcase
`ifdef AHBL_SRAM_FILL_VERIFY_EN
      // Read-back compare; only the first mismatch captures err_addr.
      if ((state_r == S_RADDR || state_r == S_RLAST) && rd_bad_s) begin
        if (mcnt_r != {LEN_W{1'b1}}) mcnt_nxt_s = mcnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
        else                         mcnt_nxt_s = mcnt_r;
        if (!err_r) begin
          err_nxt_s      = 1'b1;
          err_addr_nxt_s = daddr_r;
        end else begin
          err_nxt_s      = err_r;
        end
      end else begin
        mcnt_nxt_s = mcnt_r;
      end
`endif
    end
  end

  // Output and datapath registers; busy/done follow the state being entered.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      haddr_r    <= {ADDR_W{1'b0}};
      htrans_r   <= TR_IDLE;
      hwrite_r   <= 1'b0;
      hwdata_r   <= 32'h0000_0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_addr_r <= {ADDR_W{1'b0}};
      rem_r      <= {LEN_W{1'b0}};
      mode_r     <= 1'b0;
      pattern_r  <= 32'h0000_0000;
      dphase_r   <= 1'b0;
      daddr_r    <= {ADDR_W{1'b0}};
`ifdef AHBL_SRAM_FILL_VERIFY_EN
      base_r     <= {ADDR_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      mcnt_r     <= {LEN_W{1'b0}};
`endif
    end else begin
      haddr_r    <= haddr_nxt_s;
      htrans_r   <= htrans_nxt_s;
      hwrite_r   <= hwrite_nxt_s;
      hwdata_r   <= hwdata_nxt_s;
      busy_r     <= (state_nxt_s inside {S_ADDR, S_LAST, S_ABORT, S_RADDR, S_RLAST});
      done_r     <= (state_nxt_s == S_FIN);
      err_r      <= err_nxt_s;
      err_addr_r <= err_addr_nxt_s;
      rem_r      <= rem_nxt_s;
      mode_r     <= mode_nxt_s;
      pattern_r  <= pattern_nxt_s;
      dphase_r   <= dphase_nxt_s;
      daddr_r    <= daddr_nxt_s;
`ifdef AHBL_SRAM_FILL_VERIFY_EN
      base_r     <= base_nxt_s;
      len_r      <= len_nxt_s;
      mcnt_r     <= mcnt_nxt_s;
`endif
    end
  end

  assign bus.HADDR  = haddr_r;
  assign bus.HTRANS = htrans_r;
  assign bus.HWRITE = hwrite_r;
  assign bus.HSIZE  = 3'b010;
  assign bus.HBURST = 3'b001;
  assign bus.HWDATA = hwdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign err_addr   = err_addr_r;
`ifdef AHBL_SRAM_FILL_VERIFY_EN
  assign mismatch_cnt = mcnt_r;
`endif

endmodule
